// File: rtl/semaforo_monitor.sv
// Passive checker for the two-way traffic-light controller outputs.
// Flags encoding, conflict, sequence, dwell-time and button-causality violations.
module semaforo_monitor #(
    parameter logic [7:0] T_VERDE    = 8'd1,
    parameter logic [7:0] T_AMARELO  = 8'd3,
    parameter logic [7:0] T_VERMELHO = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] err_cnt,
    output logic [7:0] dwell_a,
    output logic       cycle_done
);

    localparam int unsigned LW = 3;
    localparam int unsigned CW = 8;

    localparam logic [LW-1:0] VERDE    = 3'b100;
    localparam logic [LW-1:0] AMARELO  = 3'b010;
    localparam logic [LW-1:0] VERMELHO = 3'b001;

    localparam logic [2:0] C_ONEHOT   = 3'd1;
    localparam logic [2:0] C_CONFLICT = 3'd2;
    localparam logic [2:0] C_SEQ      = 3'd3;
    localparam logic [2:0] C_TIME     = 3'd4;
    localparam logic [2:0] C_NOREQ    = 3'd5;

    localparam logic [CW-1:0] SAT = 8'hFF;

    logic [LW-1:0] prev_a_q, prev_a_d;
    logic [LW-1:0] prev_b_q, prev_b_d;
    logic          valid_q, valid_d;
    logic          synced_q, synced_d;
    logic          bt_pend_q, bt_pend_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          err_q, err_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          cycle_done_q, cycle_done_d;

    logic legal_a, legal_b, chg_a, chg_b, go_amarelo;
    logic v_onehot, v_conflict, v_seq, v_time, v_noreq, v_any;
    logic [2:0] first_code;

    function automatic logic is_legal(input logic [LW-1:0] c);
        return (c == VERDE) || (c == AMARELO) || (c == VERMELHO);
    endfunction

    function automatic logic step_ok(input logic [LW-1:0] p, input logic [LW-1:0] n);
        return ((p == VERDE) && (n == AMARELO)) ||
               ((p == AMARELO) && (n == VERMELHO)) ||
               ((p == VERMELHO) && (n == VERDE));
    endfunction

    // Violation detection against the previous registered sample
    always_comb begin
        legal_a    = is_legal(A);
        legal_b    = is_legal(B);
        chg_a      = valid_q && (A != prev_a_q);
        chg_b      = valid_q && (B != prev_b_q);
        go_amarelo = valid_q && (prev_a_q == VERDE) && (A == AMARELO);

        v_onehot   = !legal_a || !legal_b;
        v_conflict = (A != VERMELHO) && (B != VERMELHO);
        v_seq      = (legal_a && chg_a && !step_ok(prev_a_q, A)) ||
                     (legal_b && chg_b && !step_ok(prev_b_q, B));
        // The segment in progress at reset has unknown age, so timing waits for sync
        v_time     = legal_a && chg_a && synced_q &&
                     (((prev_a_q == AMARELO)  && (dwell_q != T_AMARELO))  ||
                      ((prev_a_q == VERMELHO) && (dwell_q != T_VERMELHO)) ||
                      ((prev_a_q == VERDE)    && (dwell_q <  T_VERDE)));
        v_noreq    = go_amarelo && !bt_pend_q && !bt;
        v_any      = v_onehot || v_conflict || v_seq || v_time || v_noreq;

        first_code = 3'd0;
        if (v_onehot)        first_code = C_ONEHOT;
        else if (v_conflict) first_code = C_CONFLICT;
        else if (v_seq)      first_code = C_SEQ;
        else if (v_time)     first_code = C_TIME;
        else if (v_noreq)    first_code = C_NOREQ;
    end

    // Next-state values for tracking state and reported outputs
    always_comb begin
        prev_a_d     = A;
        prev_b_d     = B;
        valid_d      = 1'b1;
        synced_d     = synced_q || chg_a;
        bt_pend_d    = go_amarelo ? 1'b0 : (bt_pend_q || bt);
        dwell_d      = (!valid_q || chg_a) ? 8'd1
                     : ((dwell_q == SAT) ? dwell_q : dwell_q + 8'd1);
        err_d        = err_q || v_any;
        err_code_d   = (v_any && (err_code_q == 3'd0)) ? first_code : err_code_q;
        err_cnt_d    = (v_any && (err_cnt_q != SAT)) ? err_cnt_q + 8'd1 : err_cnt_q;
        cycle_done_d = valid_q && (prev_a_q == VERMELHO) && (A == VERDE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_a_q     <= '0;
            prev_b_q     <= '0;
            valid_q      <= 1'b0;
            synced_q     <= 1'b0;
            bt_pend_q    <= 1'b0;
            dwell_q      <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            err_cnt_q    <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            prev_a_q     <= prev_a_d;
            prev_b_q     <= prev_b_d;
            valid_q      <= valid_d;
            synced_q     <= synced_d;
            bt_pend_q    <= bt_pend_d;
            dwell_q      <= dwell_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_cnt_q    <= err_cnt_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_cnt    = err_cnt_q;
    assign dwell_a    = dwell_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: vector table plus reset and saturation sequences.
module tb_semaforo_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] X = 3'b011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bt  = 1'b0;
    logic [2:0] a_in = R;
    logic [2:0] b_in = R;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] err_cnt;
    logic [7:0] dwell_a;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;

    semaforo_monitor #(
        .T_VERDE   (8'd1),
        .T_AMARELO (8'd3),
        .T_VERMELHO(8'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bt        (bt),
        .A         (a_in),
        .B         (b_in),
        .err       (err),
        .err_code  (err_code),
        .err_cnt   (err_cnt),
        .dwell_a   (dwell_a),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_before;
        logic [2:0] a;
        logic [2:0] b;
        logic       bt;
        logic       e;
        logic [2:0] code;
        logic [7:0] cnt;
        logic [7:0] dw;
        logic       cd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rb, input logic [2:0] a, input logic [2:0] b,
                                input logic btv, input logic e, input logic [2:0] code,
                                input logic [7:0] cnt, input logic [7:0] dw, input logic cd);
        vec_t v;
        v.rst_before = rb; v.a = a; v.b = b; v.bt = btv;
        v.e = e; v.code = code; v.cnt = cnt; v.dw = dw; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, got, exp);
        end
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once
    task automatic do_reset(input int idx);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_err",        idx, 8'(err),        8'd0);
        chk("rst_err_code",   idx, 8'(err_code),   8'd0);
        chk("rst_err_cnt",    idx, err_cnt,        8'd0);
        chk("rst_dwell_a",    idx, dwell_a,        8'd0);
        chk("rst_cycle_done", idx, 8'(cycle_done), 8'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic btv);
        a_in = a;
        b_in = b;
        bt   = btv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // legal run
        vq.push_back(mk(1, G, R, 1, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 3, 0));
        vq.push_back(mk(0, R, G, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, Y, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 2, 0));
        // conflict
        vq.push_back(mk(1, G, G, 0, 1, 2, 1, 1, 0));
        vq.push_back(mk(0, G, G, 0, 1, 2, 2, 2, 0));
        // bad sequence then bad encoding
        vq.push_back(mk(1, G, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, R, 0, 1, 3, 1, 1, 0));
        vq.push_back(mk(0, X, R, 0, 1, 3, 2, 1, 0));
        // amarelo too short once synced
        vq.push_back(mk(1, G, R, 1, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, R, G, 0, 1, 4, 1, 1, 0));
        // no press ever
        vq.push_back(mk(1, G, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 0, 1, 5, 1, 1, 0));
        // press during vermelho, consumed, next cycle without press
        vq.push_back(mk(1, Y, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, G, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, Y, 1, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 3, 0));
        vq.push_back(mk(0, R, G, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, Y, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, Y, R, 0, 1, 5, 1, 1, 0));
        // press in the same sample as verde->amarelo is consumed
        vq.push_back(mk(1, G, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 1, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, Y, R, 0, 0, 0, 0, 3, 0));
        vq.push_back(mk(0, R, G, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, Y, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, Y, R, 0, 1, 5, 1, 1, 0));
        // reset mid-amarelo with err set; short first segment is untimed
        vq.push_back(mk(1, Y, R, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, G, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, R, Y, 0, 0, 0, 0, 2, 0));
        vq.push_back(mk(0, G, R, 0, 0, 0, 0, 1, 1));

        foreach (vq[i]) begin
            if (vq[i].rst_before) do_reset(i);
            apply(vq[i].a, vq[i].b, vq[i].bt);
            chk("err",        i, 8'(err),        8'(vq[i].e));
            chk("err_code",   i, 8'(err_code),   8'(vq[i].code));
            chk("err_cnt",    i, err_cnt,        vq[i].cnt);
            chk("dwell_a",    i, dwell_a,        vq[i].dw);
            chk("cycle_done", i, 8'(cycle_done), 8'(vq[i].cd));
        end

        // held conflict: counter and dwell saturate at 255
        do_reset(1000);
        for (int i = 0; i < 300; i++) begin
            apply(G, G, 1'b0);
            chk("sat_err_cnt", i, err_cnt, 8'((i + 1 > 255) ? 255 : i + 1));
            chk("sat_dwell_a", i, dwell_a, 8'((i + 1 > 255) ? 255 : i + 1));
        end
        chk("sat_err",      300, 8'(err),      8'd1);
        chk("sat_err_code", 300, 8'(err_code), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Passive protocol checker that sits on the output side of the two-way traffic-light controller. It observes light buses A and B plus the pedestrian button bt, and verifies the following rules: light encoding, mutual exclusion, colour sequence, dwell times and button causality.
- It reports the first violation, counts all violations, and pulses once per completed A cycle.
- Used in benches and as an on-chip safety monitor; it never drives the controller.

Parameters:
- T_VERDE, 8'd1: minimum cycles A stays verde (1..255)
- T_AMARELO, 8'd3: exact cycles A stays amarelo (1..255)
- T_VERMELHO, 8'd2: exact cycles A stays vermelho (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- bt  in  1  pedestrian button, same signal the controller sees; sampled on rising edge of clk
- A  in  3  light A: 3'b100 verde, 3'b010 amarelo, 3'b001 vermelho
- B  in  3  light B, same encoding as A
- err  out  1  sticky; set on first violation
- err_code  out  3  first violation code: 0 none, 1 ONEHOT, 2 CONFLICT, 3 SEQ, 4 TIME, 5 NOREQ
- err_cnt  out  8  number of cycles with at least one violation; saturates at 255
- dwell_a  out  8  cycles A has held its current colour, including the current sample; saturates at 255
- cycle_done  out  1  one-cycle pulse when A re-enters verde from vermelho

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: err=0, err_code=0, err_cnt=0, dwell_a=0, cycle_done=0.
  - Internal state: prev_A, prev_B and the valid flag cleared; bt_pend=0; synced=0.
- Sampling: on each rising edge with rst=1, A, B and bt are registered. All checks compare the current sample against the previous registered sample. Flags and outputs update at the same edge, so latency is one cycle from a violating input to the err/err_cnt change.
- The first sample after reset only loads prev_A and prev_B; no SEQ or TIME check is made on it. ONEHOT and CONFLICT are checked from the first sample onward.
- ONEHOT: A or B is not one of the three legal codes. A and B are checked independently. When ONEHOT fires, SEQ and TIME are skipped for that bus in that cycle.
- CONFLICT: A!=3'b001 and B!=3'b001 in the same sample.
- SEQ: a colour change other than verde->amarelo, amarelo->vermelho or vermelho->verde, checked on A and B independently. Holding the same colour is legal.
- Dwell counter:
  - dwell_a=1 on an A colour change or on the first sample; otherwise it increments, saturating at 255.
- TIME: checked on A only, on leaving a colour, and only once synced=1.
  - Synced rule: synced becomes 1 at the first A colour change after reset. The segment that was in progress at reset is never timed.
  - Leaving amarelo with previous dwell != T_AMARELO is a violation.
  - Leaving vermelho with previous dwell != T_VERMELHO is a violation.
  - Leaving verde with previous dwell < T_VERDE is a violation.
- Button tracking:
  - bt_pend is set when bt=1 is sampled, whatever the colour of A.
  - bt_pend is cleared on the A verde->amarelo transition.
  - If bt=1 is sampled in the same cycle as that transition, the clear wins; that press is consumed.
- NOREQ: A verde->amarelo while bt_pend=0 and bt was not sampled high in that cycle.
- Error reporting:
  - Multiple codes in one cycle: err_code takes the lowest numbered one, and only if err_code==0. Once set, err_code holds until reset.
  - err_cnt increments by 1 per violating cycle regardless of how many codes fire, saturating at 255.
- cycle_done: 1 for exactly the cycle following a sample in which A moved vermelho->verde. It does not pulse on initial entry to verde after reset.
- Reset mid-operation: all state clears immediately; the checker resynchronises as after power-up.

Test Plan:
- Legal run, T=1/3/2:
  - Stimulus: rst low 1 cycle; A sequence verde x2 (bt=1 in 1st cycle), amarelo x3, vermelho x2, verde; B=vermelho except verde while A=vermelho.
  - Response: err=0, err_cnt=0, cycle_done one pulse after the verde re-entry, dwell_a sequence 1,2,1,2,3,1,2,1.
- Conflict:
  - Stimulus: A=verde, B=verde for 2 cycles.
  - Response: err=1 and err_code=2 one cycle after the first sample; err_cnt=2.
- Bad sequence and bad encoding:
  - Stimulus: A verde->vermelho, then A=3'b011.
  - Response: err_code=3; err_cnt=2; err_code stays 3 when ONEHOT fires.
- Timing:
  - Stimulus: synced run with A amarelo held 2 cycles, then vermelho.
  - Response: err_code=4 at the amarelo->vermelho sample.
- Button:
  - Stimulus: verde->amarelo with no bt ever sampled gives err_code=5. Repeat with bt pulsed during vermelho, then verde->amarelo.
  - Response: no error on the second run; bt_pend cleared afterward, so a second verde->amarelo without a press gives NOREQ.
- Reset and saturation:
  - Stimulus: assert rst asynchronously mid-amarelo, mid-cycle; separately hold a CONFLICT for 300 cycles.
  - Response: all outputs 0 at once and the first segment after reset is untimed; err_cnt saturates at 255.
